// File: rtl/hsi_link.sv
// Far-end model of the controller HSI link: deserialises framed DTX into three DAC words
// and serialises three ADC words onto DRX, with the bring-up loopback modes.
module hsi_link #(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned NUM_WORDS = 3
) (
  input  logic              MCK,
  input  logic              RST_N,
  input  logic              DSYNC,
  input  logic              DTX,
  output logic              DRX,
  input  logic              HSI_LOOPBACK_EN,
  input  logic              DTX_LOOPBACK_EN,
  input  logic              DWA_LOOPBACK_EN,
  input  logic              ADC_LOOPBACK_EN,
  input  logic              DRX_LOOPBACK_EN,
  input  logic              DWA_LOOPBACK,
  input  logic [WORD_W-1:0] DRX_DATA0,
  input  logic [WORD_W-1:0] DRX_DATA1,
  input  logic [WORD_W-1:0] DRX_DATA2,
  output logic [WORD_W-1:0] DOUT_CAR,
  output logic [WORD_W-1:0] DOUT_FRCN,
  output logic [WORD_W-1:0] DOUT_FRCA
);

  localparam int unsigned FRAME_LEN = WORD_W * NUM_WORDS;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic                 shift_en, frame_done;
  logic                 rx_bit, ser_bit, drx_next;
  logic [FRAME_LEN-2:0] rx_sr, tx_sr;
  logic [FRAME_LEN-1:0] rx_word, tx_word;

  // Frame sequencer; DSYNC always restarts at bit 0, even in the final bit cycle
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    if (state == ST_ACTIVE) begin
      shift_en = 1'b1;
      if (cnt == LAST_BIT) begin
        frame_done = 1'b1;
        state_next = ST_IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
    if (DSYNC) begin
      state_next = ST_ACTIVE;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge MCK) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Serial bit selection and DRX source priority
  always_comb begin
    rx_bit  = DWA_LOOPBACK_EN ? DWA_LOOPBACK : DTX;
    rx_word = {rx_sr, rx_bit};
    tx_word = HSI_LOOPBACK_EN ? {DOUT_CAR, DOUT_FRCN, DOUT_FRCA}
                              : {DRX_DATA0, DRX_DATA1, DRX_DATA2};
    ser_bit = 1'b0;
    if (DSYNC)
      ser_bit = tx_word[FRAME_LEN-1];
    else if (state == ST_ACTIVE && cnt != LAST_BIT)
      ser_bit = tx_sr[FRAME_LEN-2];
    drx_next = ser_bit;
    if (DTX_LOOPBACK_EN)
      drx_next = DTX;
    else if (DRX_LOOPBACK_EN)
      drx_next = DWA_LOOPBACK;
  end

  always_ff @(posedge MCK) begin
    if (!RST_N) begin
      rx_sr     <= '0;
      tx_sr     <= '0;
      DRX       <= 1'b0;
      DOUT_CAR  <= '0;
      DOUT_FRCN <= '0;
      DOUT_FRCA <= '0;
    end else begin
      DRX <= drx_next;
      if (DSYNC)
        rx_sr <= '0;
      else if (shift_en)
        rx_sr <= {rx_sr[FRAME_LEN-3:0], rx_bit};
      if (DSYNC)
        tx_sr <= tx_word[FRAME_LEN-2:0];
      else if (shift_en)
        tx_sr <= {tx_sr[FRAME_LEN-3:0], 1'b0};
      // ADC loopback overrides the deserialiser result
      if (ADC_LOOPBACK_EN) begin
        DOUT_CAR  <= DRX_DATA0;
        DOUT_FRCN <= DRX_DATA1;
        DOUT_FRCA <= DRX_DATA2;
      end else if (frame_done) begin
        DOUT_CAR  <= rx_word[FRAME_LEN-1 -: WORD_W];
        DOUT_FRCN <= rx_word[FRAME_LEN-1-WORD_W -: WORD_W];
        DOUT_FRCA <= rx_word[WORD_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_hsi_link.sv
// Scoreboarded bench for hsi_link: a frame-level reference model predicts DRX/DOUT per cycle,
// a negedge monitor compares; directed scenarios add explicit value checks.
module tb_hsi_link;

  logic        MCK = 1'b0;
  logic        RST_N = 1'b0;
  logic        DSYNC = 1'b0, DTX = 1'b0, DWA_LOOPBACK = 1'b0;
  logic        HSI_LOOPBACK_EN = 1'b0, DTX_LOOPBACK_EN = 1'b0, DWA_LOOPBACK_EN = 1'b0;
  logic        ADC_LOOPBACK_EN = 1'b0, DRX_LOOPBACK_EN = 1'b0;
  logic [15:0] DRX_DATA0 = '0, DRX_DATA1 = '0, DRX_DATA2 = '0;
  logic        DRX;
  logic [15:0] DOUT_CAR, DOUT_FRCN, DOUT_FRCA;

  int vectors = 0;
  int miscompares = 0;

  hsi_link #(.WORD_W(16), .NUM_WORDS(3)) dut (
    .MCK(MCK), .RST_N(RST_N), .DSYNC(DSYNC), .DTX(DTX), .DRX(DRX),
    .HSI_LOOPBACK_EN(HSI_LOOPBACK_EN), .DTX_LOOPBACK_EN(DTX_LOOPBACK_EN),
    .DWA_LOOPBACK_EN(DWA_LOOPBACK_EN), .ADC_LOOPBACK_EN(ADC_LOOPBACK_EN),
    .DRX_LOOPBACK_EN(DRX_LOOPBACK_EN), .DWA_LOOPBACK(DWA_LOOPBACK),
    .DRX_DATA0(DRX_DATA0), .DRX_DATA1(DRX_DATA1), .DRX_DATA2(DRX_DATA2),
    .DOUT_CAR(DOUT_CAR), .DOUT_FRCN(DOUT_FRCN), .DOUT_FRCA(DOUT_FRCA)
  );

  always #5 MCK = ~MCK;

  // Reference model: frame position (-1 idle), received bits, captured TX word
  int          m_fpos = -1;
  logic [47:0] m_acc = '0, m_txw = '0;
  logic [15:0] m_car = '0, m_frcn = '0, m_frca = '0;
  logic        m_drx = 1'b0;
  logic [48+47:0] exp_q[$];

  task automatic model_step();
    logic        active, done, rxb, ser;
    logic [47:0] w;
    if (!RST_N) begin
      m_fpos = -1; m_acc = '0; m_txw = '0;
      m_car = '0; m_frcn = '0; m_frca = '0; m_drx = 1'b0;
    end else begin
      active = (m_fpos >= 0);
      done   = (m_fpos == 47);
      rxb    = DWA_LOOPBACK_EN ? DWA_LOOPBACK : DTX;
      w      = HSI_LOOPBACK_EN ? {m_car, m_frcn, m_frca} : {DRX_DATA0, DRX_DATA1, DRX_DATA2};
      if (active) m_acc = (m_acc << 1) | 48'(rxb);
      if (DSYNC) ser = w[47];
      else if (active && m_fpos < 47) ser = m_txw[46 - m_fpos];
      else ser = 1'b0;
      if (ADC_LOOPBACK_EN) {m_car, m_frcn, m_frca} = {DRX_DATA0, DRX_DATA1, DRX_DATA2};
      else if (done) {m_car, m_frcn, m_frca} = m_acc;
      m_drx = DTX_LOOPBACK_EN ? DTX : (DRX_LOOPBACK_EN ? DWA_LOOPBACK : ser);
      if (DSYNC) begin
        m_fpos = 0; m_acc = '0; m_txw = w;
      end else if (done) m_fpos = -1;
      else if (active) m_fpos = m_fpos + 1;
    end
    exp_q.push_back({m_drx, m_car, m_frcn, m_frca});
  endtask

  // One clock: predict, let the DUT take the edge, settle just after it
  task automatic step();
    model_step();
    @(posedge MCK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    logic [48:0] e, a;
    forever begin
      @(negedge MCK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {DRX, DOUT_CAR, DOUT_FRCN, DOUT_FRCA};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL scoreboard: got %h, expected %h (t=%0t)", a, e, $time);
        end
      end
    end
  end

  // DSYNC cycle then nbits data bits; returns the DRX bits seen during the frame
  task automatic run_frame(input logic [47:0] w, input int nbits, output logic [47:0] rxw);
    rxw = '0;
    DSYNC = 1'b1; DTX = 1'b0; step(); DSYNC = 1'b0;
    rxw[47] = DRX;
    for (int i = 0; i < nbits; i++) begin
      DTX = w[47 - i];
      step();
      if (i < 47) rxw[46 - i] = DRX;
    end
    DTX = 1'b0;
  endtask

  initial begin : stim
    logic [47:0] rxw;
    logic [3:0]  pat;

    // Reset held for three cycles
    RST_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_out", {15'd0, DRX, DOUT_CAR, DOUT_FRCN, DOUT_FRCA}, 64'd0);
    end
    RST_N = 1'b1;
    step();

    // Normal frame
    DRX_DATA0 = 16'hA5A5; DRX_DATA1 = 16'h0F0F; DRX_DATA2 = 16'hFFFF;
    run_frame(48'h1234_5678_9ABC, 48, rxw);
    check("dout_car", 64'(DOUT_CAR), 64'h1234);
    check("dout_frcn", 64'(DOUT_FRCN), 64'h5678);
    check("dout_frca", 64'(DOUT_FRCA), 64'h9ABC);
    check("drx_frame", 64'(rxw), 64'hA5A5_0F0F_FFFF);
    step();
    check("drx_idle", 64'(DRX), 64'd0);

    // HSI loopback: frame 2 returns frame 1's words
    HSI_LOOPBACK_EN = 1'b1;
    run_frame(48'hDEAD_BEEF_CAFE, 48, rxw);
    step(); step();
    run_frame(48'h0, 48, rxw);
    check("hsi_loop_drx", 64'(rxw), 64'hDEAD_BEEF_CAFE);
    check("hsi_loop_dout", {16'd0, DOUT_CAR, DOUT_FRCN, DOUT_FRCA}, 64'd0);
    HSI_LOOPBACK_EN = 1'b0;
    step();

    // DTX loopback, no framing
    DTX_LOOPBACK_EN = 1'b1;
    pat = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      DTX = pat[3 - i];
      step();
      check("dtx_loop", 64'(DRX), 64'(pat[3 - i]));
    end
    DTX_LOOPBACK_EN = 1'b0; DTX = 1'b0;
    step();

    // ADC loopback, one cycle, no frame
    ADC_LOOPBACK_EN = 1'b1;
    DRX_DATA0 = 16'h0001; DRX_DATA1 = 16'h0000; DRX_DATA2 = 16'h0000;
    step();
    check("adc_loop", 64'(DOUT_CAR), 64'h0001);
    ADC_LOOPBACK_EN = 1'b0;
    step();

    // Aborted frame leaves DOUT untouched; the following full frame loads
    run_frame(48'hFFFF_FFFF_FFFF, 20, rxw);
    check("abort_hold", {16'd0, DOUT_CAR, DOUT_FRCN, DOUT_FRCA}, 64'h0001_0000_0000);
    run_frame(48'h1111_2222_3333, 48, rxw);
    check("restart_dout", {16'd0, DOUT_CAR, DOUT_FRCN, DOUT_FRCA}, 64'h1111_2222_3333);
    step();

    // Randomized traffic, modes reshuffled periodically
    for (int c = 0; c < 6000; c++) begin
      if (c % 256 == 0) begin
        HSI_LOOPBACK_EN = ($urandom_range(0, 3) == 0);
        DTX_LOOPBACK_EN = ($urandom_range(0, 5) == 0);
        DWA_LOOPBACK_EN = ($urandom_range(0, 3) == 0);
        ADC_LOOPBACK_EN = ($urandom_range(0, 5) == 0);
        DRX_LOOPBACK_EN = ($urandom_range(0, 4) == 0);
      end
      RST_N        = ($urandom_range(0, 499) != 0);
      DSYNC        = ($urandom_range(0, 44) == 0);
      DTX          = 1'($urandom);
      DWA_LOOPBACK = 1'($urandom);
      DRX_DATA0    = 16'($urandom);
      DRX_DATA1    = 16'($urandom);
      DRX_DATA2    = 16'($urandom);
      step();
    end

    RST_N = 1'b1; DSYNC = 1'b0;
    {HSI_LOOPBACK_EN, DTX_LOOPBACK_EN, DWA_LOOPBACK_EN, ADC_LOOPBACK_EN, DRX_LOOPBACK_EN} = '0;
    step();
    @(negedge MCK);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
